branch_fetch_ctrl: RTL and testbench

Fetch-side initiator for the branch compare unit. Holds the PC and reads 20-bit instruction words from a combinational instruction ROM. When an instruction has its branch flag set (bit BR_BIT), it drives the opcode and RS field to the compare unit and samples the returned taken bit. It then either redirects the PC and flushes downstream for FLUSH_CYC cycles, or falls through to the next instruction.

---
 rtl/branch_fetch_ctrl_pkg.sv | 26 ++
 rtl/branch_fetch_ctrl_target_adder.sv | 13 +
 rtl/branch_fetch_ctrl.sv | 118 +++++++++++
 tb/tb_branch_fetch_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_fetch_ctrl_pkg.sv
// Shared definitions for the branch fetch controller: field positions,
// address widths, FSM state codes and the branch target computation.
package branch_fetch_ctrl_pkg;

    localparam int ADDR_W   = 8;   // PC / instruction address width
    localparam int INSTR_W  = 20;  // instruction word width
    localparam int BR_BIT   = 14;  // instruction bit marking a branch
    localparam int OFFSET_W = 8;   // signed branch offset lives in instr[OFFSET_W-1:0]
    localparam int RS_HI    = 19;  // RS field upper bit
    localparam int RS_LO    = 15;  // RS field lower bit

    typedef logic [1:0] state_t;

    localparam state_t FETCH   = 2'd0;
    localparam state_t RESOLVE = 2'd1;
    localparam state_t FLUSH   = 2'd2;

    // Next PC of a taken branch: pc + 1 + sign-extended offset, wrapping mod 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] calc_target(
        input logic [ADDR_W-1:0]   pc,
        input logic [OFFSET_W-1:0] offset
    );
        return pc + ADDR_W'(1) + ADDR_W'(signed'(offset));
    endfunction

endpackage

// File: rtl/branch_fetch_ctrl_target_adder.sv
// branch_target_adder: combinational taken-branch target, pc + 1 + sext(offset),
// wrapping modulo 2^ADDR_W.
module branch_target_adder
    import branch_fetch_ctrl_pkg::*;
(
    input  logic [ADDR_W-1:0]   pc,
    input  logic [OFFSET_W-1:0] offset,
    output logic [ADDR_W-1:0]   target
);

    assign target = calc_target(pc, offset);

endmodule

// File: rtl/branch_fetch_ctrl.sv
// branch_fetch_ctrl: fetch-side initiator for the branch compare unit.
// Fetches from a combinational ROM, resolves branches in one RESOLVE cycle
// using the compare unit's combinational taken bit, then redirects and
// flushes for FLUSH_CYC cycles or falls through.
// Optional feature macro: BR_STATS_EN adds saturating taken/not-taken counters.
module branch_fetch_ctrl
    import branch_fetch_ctrl_pkg::*;
#(
    parameter int FLUSH_CYC = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_in,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [INSTR_W-1:0]  br_opc_out,
    output logic [4:0]          br_rs_out,
    input  logic                br_taken_in,
    output logic [INSTR_W-1:0]  instr_out,
    output logic                instr_valid,
    output logic                flush,
    output logic [ADDR_W-1:0]   pc_out
`ifdef BR_STATS_EN
    ,
    output logic [15:0]         taken_cnt,
    output logic [15:0]         nottaken_cnt
`endif
);

    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] ir;
    state_t             state;
    logic [7:0]         flush_cnt;
    logic [ADDR_W-1:0]  br_target;

    branch_target_adder u_target (
        .pc     (pc),
        .offset (ir[OFFSET_W-1:0]),
        .target (br_target)
    );

    assign imem_addr  = pc;
    assign pc_out     = pc;
    assign instr_out  = ir;
    assign br_opc_out = ir;
    assign br_rs_out  = ir[RS_HI:RS_LO];

    // Fetch / resolve / flush sequencing; a stall freezes every register.
    // NOTE: sequential state uses non-blocking (<=) so all registers update
    // together from pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= '0;
            ir          <= '0;
            state       <= FETCH;
            instr_valid <= 1'b0;
            flush       <= 1'b0;
            flush_cnt   <= '0;
        end else if (!stall_in) begin
            case (state)
                FETCH: begin
                    ir          <= imem_rdata;
                    instr_valid <= 1'b1;
                    if (imem_rdata[BR_BIT]) begin
                        state <= RESOLVE;
                    end else begin
                        pc <= pc + ADDR_W'(1);
                    end
                end
                RESOLVE: begin
                    instr_valid <= 1'b0;
                    if (br_taken_in) begin
                        pc <= br_target;
                        if (FLUSH_CYC == 0) begin
                            state <= FETCH;
                        end else begin
                            flush     <= 1'b1;
                            flush_cnt <= 8'(FLUSH_CYC - 1);
                            state     <= FLUSH;
                        end
                    end else begin
                        pc    <= pc + ADDR_W'(1);
                        state <= FETCH;
                    end
                end
                FLUSH: begin
                    instr_valid <= 1'b0;
                    if (flush_cnt == 8'd0) begin
                        flush <= 1'b0;
                        state <= FETCH;
                    end else begin
                        flush_cnt <= flush_cnt - 8'd1;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

`ifdef BR_STATS_EN
    // Saturating per-outcome branch counters, advanced on unstalled RESOLVE cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            taken_cnt    <= '0;
            nottaken_cnt <= '0;
        end else if (!stall_in && state == RESOLVE) begin
            if (br_taken_in) begin
                if (taken_cnt != 16'hFFFF) taken_cnt <= taken_cnt + 16'd1;
            end else begin
                if (nottaken_cnt != 16'hFFFF) nottaken_cnt <= nottaken_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_fetch_ctrl.sv
// Self-checking bench for branch_fetch_ctrl. An instruction-level program
// walk predicts what every clock edge must leave on the outputs; predictions
// go into a queue and a separate monitor compares them on the falling edge.
// Build with BR_STATS_EN defined to also check the branch counters.
module tb_branch_fetch_ctrl;

    localparam int FC = 2;
    localparam int BR = 14;

    typedef struct packed {
        logic [7:0]  pc;
        logic        valid;
        logic        flush;
        logic [19:0] instr;
    } obs_t;

    logic        clk;
    logic        rst_n;
    logic        stall_in;
    logic [7:0]  imem_addr;
    logic [19:0] imem_rdata;
    logic [19:0] br_opc_out;
    logic [4:0]  br_rs_out;
    logic        br_taken_in;
    logic [19:0] instr_out;
    logic        instr_valid;
    logic        flush;
    logic [7:0]  pc_out;
`ifdef BR_STATS_EN
    logic [15:0] taken_cnt;
    logic [15:0] nottaken_cnt;
    int          m_taken;
    int          m_nottaken;
`endif

    logic [19:0] rom [256];
    assign imem_rdata = rom[imem_addr];

    branch_fetch_ctrl #(.FLUSH_CYC(FC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_in     (stall_in),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .br_opc_out   (br_opc_out),
        .br_rs_out    (br_rs_out),
        .br_taken_in  (br_taken_in),
        .instr_out    (instr_out),
        .instr_valid  (instr_valid),
        .flush        (flush),
        .pc_out       (pc_out)
`ifdef BR_STATS_EN
        ,
        .taken_cnt    (taken_cnt),
        .nottaken_cnt (nottaken_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    obs_t       exp_q[$];
    obs_t       last_exp;
    logic       plan[$];
    logic [7:0] m_pc;
    int         resolve_stalls;
    int         n_checks;
    int         n_pass;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic obs_t mk(input logic [7:0] pc, input logic v, input logic f, input logic [19:0] ins);
        obs_t o;
        o.pc = pc; o.valid = v; o.flush = f; o.instr = ins;
        return o;
    endfunction

    // Apply inputs for one clock edge and record what that edge must produce.
    task automatic drive_edge(input logic rst, input logic stall, input logic taken, input obs_t e);
        rst_n       = ~rst;
        stall_in    = stall;
        br_taken_in = taken;
        exp_q.push_back(e);
        last_exp = e;
        @(posedge clk);
        #1;
    endtask

    // One unstalled edge, preceded by forced and random stall edges that must hold everything.
    task automatic step(input logic taken, input logic is_res, input obs_t e, input int pct, input int n_forced);
        int extra = 0;
        for (int s = 0; s < n_forced; s++) drive_edge(1'b0, 1'b1, 1'($urandom_range(1)), last_exp);
        while (extra < 3 && int'($urandom_range(99)) < pct) begin
            drive_edge(1'b0, 1'b1, 1'($urandom_range(1)), last_exp);
            extra++;
        end
        drive_edge(1'b0, 1'b0, is_res ? taken : 1'($urandom_range(1)), e);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) drive_edge(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), mk(8'd0, 1'b0, 1'b0, 20'd0));
        m_pc = 8'd0;
`ifdef BR_STATS_EN
        m_taken = 0;
        m_nottaken = 0;
`endif
    endtask

    function automatic logic [7:0] branch_dest(input logic [7:0] pc, input logic [19:0] w, input logic t);
        int off;
        off = w[7] ? int'(w[7:0]) - 256 : int'(w[7:0]);
        return t ? 8'((int'(pc) + 1 + off) & 255) : 8'((int'(pc) + 1) & 255);
    endfunction

    // Execute n instructions of the program from the model PC.
    task automatic exec(input int n, input int pct);
        logic [19:0] w;
        logic        t;
        logic [7:0]  tgt;
        for (int i = 0; i < n; i++) begin
            w = rom[m_pc];
            if (!w[BR]) begin
                m_pc = m_pc + 8'd1;
                step(1'b0, 1'b0, mk(m_pc, 1'b1, 1'b0, w), pct, 0);
            end else begin
                step(1'b0, 1'b0, mk(m_pc, 1'b1, 1'b0, w), pct, 0);
                t   = (plan.size() > 0) ? plan.pop_front() : 1'($urandom_range(1));
                tgt = branch_dest(m_pc, w, t);
                step(t, 1'b1, mk(tgt, 1'b0, t && (FC > 0), w), pct, resolve_stalls);
                if (t) for (int k = 1; k <= FC; k++) step(1'b0, 1'b0, mk(tgt, 1'b0, k < FC, w), pct, 0);
                m_pc = tgt;
`ifdef BR_STATS_EN
                if (t) m_taken++; else m_nottaken++;
`endif
            end
        end
    endtask

    // Taken branch at the model PC, with reset applied on the second flush cycle.
    task automatic branch_then_reset();
        logic [19:0] w;
        logic [7:0]  tgt;
        w   = rom[m_pc];
        tgt = branch_dest(m_pc, w, 1'b1);
        step(1'b0, 1'b0, mk(m_pc, 1'b1, 1'b0, w), 0, 0);
        step(1'b1, 1'b1, mk(tgt, 1'b0, 1'b1, w), 0, 0);
        step(1'b0, 1'b0, mk(tgt, 1'b0, 1'b1, w), 0, 0);
        do_reset(1);
    endtask

    task automatic check_stats();
`ifdef BR_STATS_EN
        check("taken_cnt", 32'(taken_cnt), 32'(m_taken));
        check("nottaken_cnt", 32'(nottaken_cnt), 32'(m_nottaken));
`endif
    endtask

    // Monitor: compares each edge's outcome against the oldest prediction.
    initial begin
        obs_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc_out", 32'(pc_out), 32'(e.pc));
                check("imem_addr", 32'(imem_addr), 32'(e.pc));
                check("instr_valid", 32'(instr_valid), 32'(e.valid));
                check("flush", 32'(flush), 32'(e.flush));
                check("instr_out", 32'(instr_out), 32'(e.instr));
                check("br_opc_out", 32'(br_opc_out), 32'(e.instr));
                check("br_rs_out", 32'(br_rs_out), 32'(e.instr[19:15]));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_pass = 0;
        resolve_stalls = 0;
        for (int a = 0; a < 256; a++) begin
            rom[a] = 20'($urandom);
            rom[a][BR] = (int'($urandom_range(99)) < 30);
        end
        for (int a = 0; a < 9; a++) rom[a][BR] = 1'b0;
        rom[5][BR] = 1'b1;      rom[5][7:0] = 8'h03;     // 5 -> 9
        rom[9][BR] = 1'b1;      rom[9][7:0] = 8'hF4;     // 9 -> 0xFE (negative wrap)
        rom[8'hFE][BR] = 1'b1;  rom[8'hFE][7:0] = 8'h05; // 0xFE -> 0x04
        rom[8'hFF][BR] = 1'b0;                           // falls through to 0
        rom[8'h40][BR] = 1'b1;  rom[8'h40][7:0] = 8'hFF; // self-loop

        // Straight-line fetch, taken branch with flush, wrap paths; 2 taken + 1 not-taken.
        do_reset(2);
        plan = '{1'b1, 1'b1, 1'b0};
        exec(9, 0);
        check_stats();

        // Not-taken at 5 falls through to 6; then 9 -> 0xFE -> 0x04.
        do_reset(1);
        plan = '{1'b0, 1'b1, 1'b1};
        exec(11, 0);

        // Three stall cycles while resolving the branch at 5, then taken.
        exec(1, 0);
        resolve_stalls = 3;
        plan = '{1'b1};
        exec(1, 0);
        resolve_stalls = 0;

        // Reset during the second flush cycle drops the redirect.
        branch_then_reset();
        check_stats();

        // Randomized program walk with random stalls and outcomes.
        exec(600, 20);
        check_stats();
        do_reset(1);
        check_stats();

        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
